// File: rtl/cv32e40p_alu_tmr_ctrl_if.sv
// Bundle between the EX-stage ALU replicas and the TMR fault controller.
// master = EX side (drives replica outputs), slave = controller (drives status).
interface cv32e40p_alu_tmr_ctrl_if #(
  parameter int CNT_W = 4
);
  logic                 alu_valid;
  logic [95:0]          alu_result;
  logic [2:0]           alu_cmp;
  logic                 clear_cnt;
  logic [2:0]           replica_mask;
  logic                 mismatch;
  logic                 retry;
  logic                 stall;
  logic                 fatal;
  logic [3*CNT_W-1:0]   err_cnt;

  modport master (
    output alu_valid, alu_result, alu_cmp, clear_cnt,
    input  replica_mask, mismatch, retry, stall, fatal, err_cnt
  );

  modport slave (
    input  alu_valid, alu_result, alu_cmp, clear_cnt,
    output replica_mask, mismatch, retry, stall, fatal, err_cnt
  );
endinterface

// File: rtl/cv32e40p_alu_tmr_ctrl.sv
// Fault controller for the triplicated EX ALU: votes, counts, masks, retries.
// Ports: clk, rst_n (sync, active low), bus (slave: replica in, status out).
module cv32e40p_alu_tmr_ctrl #(
  parameter int CNT_W        = 4,
  parameter int FAULT_THRESH = 8,
  parameter int MAX_RETRY    = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  cv32e40p_alu_tmr_ctrl_if.slave bus
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] THR  = CNT_W'(FAULT_THRESH);
  localparam logic [RW-1:0]    RMAX = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE,
    RETRY,
    FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic             mis_q, mis_d;
  logic             ret_q, ret_d;

  logic [32:0] w0, w1, w2;
  logic        eq01, eq02, eq12;
  logic        agree, single, nomaj;
  logic [1:0]  k;
  logic [CNT_W-1:0] inc;

  assign w0 = {bus.alu_cmp[0], bus.alu_result[31:0]};
  assign w1 = {bus.alu_cmp[1], bus.alu_result[63:32]};
  assign w2 = {bus.alu_cmp[2], bus.alu_result[95:64]};

  assign eq01 = (w0 == w1);
  assign eq02 = (w0 == w2);
  assign eq12 = (w1 == w2);

  // Vote only among unmasked replicas; with one masked, a
  // disagreement of the surviving pair has no majority.
  always_comb begin
    agree  = 1'b0;
    single = 1'b0;
    k      = 2'd0;
    unique case (mask_q)
      3'b000: begin
        agree = eq01 & eq02;
        unique case (1'b1)
          (eq12 & !eq01): begin
            single = 1'b1;
            k      = 2'd0;
          end
          (eq02 & !eq01): begin
            single = 1'b1;
            k      = 2'd1;
          end
          (eq01 & !eq02): begin
            single = 1'b1;
            k      = 2'd2;
          end
          default: ;
        endcase
      end
      3'b001:  agree = eq12;
      3'b010:  agree = eq02;
      3'b100:  agree = eq01;
      default: agree = 1'b1;
    endcase
  end

  assign nomaj = !agree & !single;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    mis_d   = 1'b0;
    ret_d   = 1'b0;
    inc     = cnt_q[k];
    if (state_q == FAIL) begin
      mis_d = mis_q;
      ret_d = ret_q;
    end else begin
      if (bus.clear_cnt) begin
        for (int i = 0; i < 3; i++) cnt_d[i] = '0;
      end
      if (bus.alu_valid) begin
        unique case (1'b1)
          agree: begin
            if (state_q == RETRY) begin
              state_d = IDLE;
              rcnt_d  = '0;
            end
          end
          single: begin
            mis_d   = 1'b1;
            state_d = IDLE;
            rcnt_d  = '0;
            // A same-cycle clear suppresses both the increment
            // and any mask decision it would have triggered.
            if (!bus.clear_cnt) begin
              if (cnt_q[k] != CMAX) inc = cnt_q[k] + CNT_W'(1);
              cnt_d[k] = inc;
              if (inc == THR && !mask_q[k]) begin
                if (mask_q != 3'b000) state_d = FAIL;
                else mask_d[k] = 1'b1;
              end
            end
          end
          nomaj: begin
            if (state_q == IDLE) begin
              ret_d   = 1'b1;
              rcnt_d  = RW'(1);
              state_d = RETRY;
            end else if (rcnt_q < RMAX) begin
              ret_d  = 1'b1;
              rcnt_d = rcnt_q + RW'(1);
            end else begin
              state_d = FAIL;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      rcnt_q  <= '0;
      mis_q   <= 1'b0;
      ret_q   <= 1'b0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      rcnt_q  <= rcnt_d;
      mis_q   <= mis_d;
      ret_q   <= ret_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.replica_mask = mask_q;
  assign bus.mismatch     = mis_q;
  assign bus.retry        = ret_q;
  assign bus.stall        = (state_q != IDLE);
  assign bus.fatal        = (state_q == FAIL);
  assign bus.err_cnt      = {cnt_q[2], cnt_q[1], cnt_q[0]};

endmodule

// File: tb/tb_cv32e40p_alu_tmr_ctrl.sv
// Self-checking bench for the ALU TMR controller.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_cv32e40p_alu_tmr_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cv32e40p_alu_tmr_ctrl_if #(.CNT_W(4)) bus ();

  cv32e40p_alu_tmr_ctrl #(
    .CNT_W(4),
    .FAULT_THRESH(8),
    .MAX_RETRY(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: mode 0 idle, 1 retry, 2 fail
  logic [3:0] m_cnt [3];
  bit   [2:0] m_mask;
  int         m_mode;
  int         m_rc;
  bit         m_mis;
  bit         m_ret;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_cnt[i] = 4'd0;
    m_mask = 3'b000;
    m_mode = 0;
    m_rc   = 0;
    m_mis  = 1'b0;
    m_ret  = 1'b0;
  endfunction

  function automatic void model_step();
    logic [32:0] w [3];
    int n;
    int eqc [3];
    bit all_eq;
    int odd;
    int left;
    for (int i = 0; i < 3; i++)
      w[i] = {bus.alu_cmp[i], bus.alu_result[32*i +: 32]};
    if (m_mode == 2) return;
    m_mis = 1'b0;
    m_ret = 1'b0;
    if (bus.clear_cnt)
      for (int i = 0; i < 3; i++) m_cnt[i] = 4'd0;
    if (!bus.alu_valid) return;
    n = 0;
    all_eq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      eqc[i] = 0;
      if (!m_mask[i]) n++;
    end
    for (int i = 0; i < 3; i++)
      for (int j = i + 1; j < 3; j++)
        if (!m_mask[i] && !m_mask[j]) begin
          if (w[i] != w[j]) all_eq = 1'b0;
          else begin
            eqc[i]++;
            eqc[j]++;
          end
        end
    odd = -1;
    if (n == 3 && !all_eq)
      for (int i = 0; i < 3; i++)
        if (eqc[i] == 0 && eqc[(i+1)%3] == 1 && eqc[(i+2)%3] == 1)
          odd = i;
    if (all_eq) begin
      if (m_mode == 1) begin
        m_mode = 0;
        m_rc   = 0;
      end
    end else if (odd >= 0) begin
      m_mis  = 1'b1;
      m_mode = 0;
      m_rc   = 0;
      if (!bus.clear_cnt) begin
        if (m_cnt[odd] < 4'd15) m_cnt[odd] = m_cnt[odd] + 4'd1;
        if (m_cnt[odd] == 4'd8) begin
          left = n - 1;
          if (left < 2) m_mode = 2;
          else m_mask[odd] = 1'b1;
        end
      end
    end else begin
      if (m_mode == 0) begin
        m_ret  = 1'b1;
        m_rc   = 1;
        m_mode = 1;
      end else if (m_rc < 2) begin
        m_rc++;
        m_ret = 1'b1;
      end else begin
        m_mode = 2;
      end
    end
  endfunction

  task automatic op(input bit v, input logic [31:0] a0, input logic [31:0] a1,
                    input logic [31:0] a2, input logic [2:0] c, input bit clr);
    bus.alu_valid  = v;
    bus.alu_result = {a2, a1, a0};
    bus.alu_cmp    = c;
    bus.clear_cnt  = clr;
    @(posedge clk);
    model_step();
    #1;
    bus.alu_valid = 1'b0;
    bus.clear_cnt = 1'b0;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.alu_valid = 1'b0;
    bus.clear_cnt = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.replica_mask !== 3'b000) begin
      errors++;
      $display("FAIL reset_mask got %b exp 000", bus.replica_mask);
    end
    checks++;
    if ({bus.mismatch, bus.retry, bus.stall, bus.fatal} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000",
               {bus.mismatch, bus.retry, bus.stall, bus.fatal});
    end
    checks++;
    if (bus.err_cnt !== 12'h000) begin
      errors++;
      $display("FAIL reset_cnt got %h exp 000", bus.err_cnt);
    end
  endtask

  task automatic test_agree();
    for (int i = 0; i < 5; i++) begin
      op(1'b1, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 3'b000, 1'b0);
      checks++;
      if ({bus.mismatch, bus.retry, bus.stall} !== 3'b000 ||
          bus.err_cnt !== 12'h000 || bus.replica_mask !== 3'b000) begin
        errors++;
        $display("FAIL agree[%0d] got m%b r%b s%b cnt %h mask %b exp all 0",
                 i, bus.mismatch, bus.retry, bus.stall, bus.err_cnt,
                 bus.replica_mask);
      end
    end
  endtask

  task automatic test_count_mask();
    logic [11:0] ecnt;
    logic [2:0]  emask;
    for (int i = 0; i < 9; i++) begin
      op(1'b1, 32'h1, 32'hDEAD_BEEF, 32'h1, 3'b000, 1'b0);
      ecnt  = (i < 8) ? 12'(i + 1) << 4 : 12'h080;
      emask = (i >= 7) ? 3'b010 : 3'b000;
      checks++;
      if (bus.mismatch !== (i < 8)) begin
        errors++;
        $display("FAIL count_pulse[%0d] got %b exp %b", i, bus.mismatch, i < 8);
      end
      checks++;
      if (bus.err_cnt !== ecnt || bus.replica_mask !== emask) begin
        errors++;
        $display("FAIL count_state[%0d] got cnt %h mask %b exp cnt %h mask %b",
                 i, bus.err_cnt, bus.replica_mask, ecnt, emask);
      end
    end
  endtask

  task automatic test_pair_retry();
    op(1'b1, 32'h5, 32'hDEAD_BEEF, 32'h6, 3'b000, 1'b0);
    checks++;
    if (bus.retry !== 1'b1 || bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL pair_nomaj got r%b s%b exp r1 s1", bus.retry, bus.stall);
    end
    op(1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0);
    checks++;
    if (bus.retry !== 1'b0 || bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL pair_hold got r%b s%b exp r0 s1", bus.retry, bus.stall);
    end
    op(1'b1, 32'h7, 32'h0, 32'h7, 3'b000, 1'b0);
    checks++;
    if (bus.retry !== 1'b0 || bus.stall !== 1'b0 || bus.fatal !== 1'b0) begin
      errors++;
      $display("FAIL pair_recover got r%b s%b f%b exp 000",
               bus.retry, bus.stall, bus.fatal);
    end
  endtask

  task automatic test_fail();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      op(1'b1, 32'h1, 32'h2, 32'h3, 3'b000, 1'b0);
      checks++;
      if (bus.retry !== (i < 2) || bus.fatal !== (i == 2) || bus.stall !== 1'b1) begin
        errors++;
        $display("FAIL fail_seq[%0d] got r%b f%b s%b exp r%b f%b s1",
                 i, bus.retry, bus.fatal, bus.stall, i < 2, i == 2);
      end
    end
    op(1'b1, 32'h9, 32'h9, 32'h9, 3'b000, 1'b0);
    op(1'b1, 32'h1, 32'h9, 32'h9, 3'b000, 1'b1);
    checks++;
    if (bus.fatal !== 1'b1 || bus.stall !== 1'b1 || bus.retry !== 1'b0) begin
      errors++;
      $display("FAIL fail_sticky got f%b s%b r%b exp f1 s1 r0",
               bus.fatal, bus.stall, bus.retry);
    end
    do_reset();
    checks++;
    if (bus.fatal !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL fail_exit got f%b s%b exp 00", bus.fatal, bus.stall);
    end
  endtask

  task automatic test_clear_wins();
    do_reset();
    for (int i = 0; i < 7; i++)
      op(1'b1, 32'h1, 32'hDEAD_BEEF, 32'h1, 3'b000, 1'b0);
    checks++;
    if (bus.err_cnt !== 12'h070) begin
      errors++;
      $display("FAIL clear_pre got %h exp 070", bus.err_cnt);
    end
    op(1'b1, 32'h1, 32'hDEAD_BEEF, 32'h1, 3'b000, 1'b1);
    checks++;
    if (bus.err_cnt !== 12'h000 || bus.replica_mask !== 3'b000) begin
      errors++;
      $display("FAIL clear_wins got cnt %h mask %b exp 000 000",
               bus.err_cnt, bus.replica_mask);
    end
  endtask

  task automatic test_reset_in_retry();
    do_reset();
    op(1'b1, 32'hA, 32'h4, 32'h4, 3'b000, 1'b0);
    op(1'b1, 32'hA, 32'h4, 32'h4, 3'b000, 1'b0);
    op(1'b1, 32'h1, 32'h2, 32'h3, 3'b000, 1'b0);
    checks++;
    if (bus.stall !== 1'b1 || bus.err_cnt !== 12'h002) begin
      errors++;
      $display("FAIL rir_pre got s%b cnt %h exp s1 002", bus.stall, bus.err_cnt);
    end
    rst_n          = 1'b0;
    bus.alu_valid  = 1'b1;
    bus.alu_result = {32'h3, 32'h2, 32'h1};
    @(posedge clk);
    model_reset();
    #1;
    rst_n         = 1'b1;
    bus.alu_valid = 1'b0;
    checks++;
    if (bus.stall !== 1'b0 || bus.retry !== 1'b0 || bus.err_cnt !== 12'h000 ||
        bus.fatal !== 1'b0) begin
      errors++;
      $display("FAIL rir_post got s%b r%b f%b cnt %h exp 0 0 0 000",
               bus.stall, bus.retry, bus.fatal, bus.err_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] base;
    logic [31:0] a [3];
    logic [2:0]  c;
    logic [11:0] ecnt;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
        do_reset();
        continue;
      end
      base = $urandom;
      c    = {3{1'($urandom_range(0, 1))}};
      for (int i = 0; i < 3; i++) begin
        a[i] = base;
        if ($urandom_range(0, 99) < ((i == 1) ? 40 : 12))
          a[i] = base ^ 32'($urandom_range(1, 2));
        if ($urandom_range(0, 99) < 3) c[i] = ~c[i];
      end
      op($urandom_range(0, 9) < 8, a[0], a[1], a[2], c,
         $urandom_range(0, 99) < 3);
      ecnt = {m_cnt[2], m_cnt[1], m_cnt[0]};
      checks++;
      if (bus.replica_mask !== m_mask || bus.err_cnt !== ecnt) begin
        errors++;
        $display("FAIL rnd_state[%0d] got mask %b cnt %h exp mask %b cnt %h",
                 n, bus.replica_mask, bus.err_cnt, m_mask, ecnt);
      end
      checks++;
      if (bus.mismatch !== m_mis || bus.retry !== m_ret ||
          bus.stall !== (m_mode != 0) || bus.fatal !== (m_mode == 2)) begin
        errors++;
        $display("FAIL rnd_flags[%0d] got m%b r%b s%b f%b exp m%b r%b s%b f%b",
                 n, bus.mismatch, bus.retry, bus.stall, bus.fatal,
                 m_mis, m_ret, m_mode != 0, m_mode == 2);
      end
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.alu_valid  = 1'b0;
    bus.alu_result = '0;
    bus.alu_cmp    = '0;
    bus.clear_cnt  = 1'b0;
    model_reset();
    test_reset();
    test_agree();
    test_count_mask();
    test_pair_retry();
    test_fail();
    test_clear_wins();
    test_reset_in_retry();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
